// File: rtl/mem_access_unit.sv
// Memory-access stage controller: validates a load/store, pulses the data-memory
// enables for MEM_LAT cycles, then returns one extended response beat to MEM/WB.
module mem_access_unit #(
    parameter int XLEN      = 64,
    parameter int MEM_BYTES = 4096,
    parameter int MEM_LAT   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_write_en,
    output logic            mem_read_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data_input,
    output logic [1:0]      store_format,
    output logic [2:0]      load_format,
    input  logic [XLEN-1:0] mem_data_output,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic            resp_we,
    output logic            resp_misalign,
    output logic            resp_fault,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [XLEN-1:0] MEM_TOP  = XLEN'(MEM_BYTES);
    localparam logic [2:0]      LAT_LAST = 3'(MEM_LAT - 1);

    state_t          state, state_next;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic [2:0]      lat_cnt;
    logic [XLEN-1:0] rdata_q;
    logic [4:0]      resp_rd_q;
    logic            resp_we_q;
    logic            misalign_q;
    logic            fault_q;

    logic [XLEN-1:0] size_x;
    logic            illegal_f3;
    logic            misalign_chk;
    logic            fault_chk;
    logic            lat_last;
    logic [XLEN-1:0] load_ext;

    // The range test short-circuits on addr >= MEM_BYTES, so addr+size cannot wrap where it matters.
    always_comb begin
        size_x       = XLEN'(1) << req_funct3[1:0];
        illegal_f3   = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
        misalign_chk = illegal_f3 || ((req_addr & (size_x - XLEN'(1))) != '0);
        fault_chk    = (req_addr >= MEM_TOP) || ((req_addr + size_x) > MEM_TOP);
        lat_last     = (lat_cnt == LAT_LAST);
    end

    always_comb begin
        load_ext = mem_data_output;
        case (funct3_q[1:0])
            2'b00: load_ext = funct3_q[2] ? {{(XLEN-8){1'b0}}, mem_data_output[7:0]}
                                          : {{(XLEN-8){mem_data_output[7]}}, mem_data_output[7:0]};
            2'b01: load_ext = funct3_q[2] ? {{(XLEN-16){1'b0}}, mem_data_output[15:0]}
                                          : {{(XLEN-16){mem_data_output[15]}}, mem_data_output[15:0]};
            2'b10: load_ext = funct3_q[2] ? {{(XLEN-32){1'b0}}, mem_data_output[31:0]}
                                          : {{(XLEN-32){mem_data_output[31]}}, mem_data_output[31:0]};
            default: load_ext = mem_data_output;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            lat_cnt    <= '0;
            rdata_q    <= '0;
            resp_rd_q  <= '0;
            resp_we_q  <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (req_valid) begin
                    is_store_q <= req_is_store;
                    funct3_q   <= req_funct3;
                    addr_q     <= req_addr;
                    wdata_q    <= req_wdata;
                    rd_q       <= req_rd;
                    lat_cnt    <= '0;
                    rdata_q    <= '0;
                    resp_rd_q  <= '0;
                    resp_we_q  <= 1'b0;
                    misalign_q <= misalign_chk;
                    fault_q    <= fault_chk;
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lat_last && !is_store_q) begin
                        rdata_q   <= load_ext;
                        resp_rd_q <= rd_q;
                        resp_we_q <= (rd_q != 5'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory pins and response fields read as zero outside their own state.
    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        busy           = 1'b1;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_addr       = '0;
        mem_data_input = '0;
        store_format   = 2'b00;
        load_format    = 3'b000;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_rd        = '0;
        resp_we        = 1'b0;
        resp_misalign  = 1'b0;
        resp_fault     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = (misalign_chk || fault_chk) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_write_en   = is_store_q;
                mem_read_en    = !is_store_q;
                mem_addr       = addr_q;
                mem_data_input = wdata_q;
                if (is_store_q) begin
                    store_format = funct3_q[1:0];
                end else begin
                    load_format = (funct3_q[1:0] == 2'b11) ? 3'b101 : {1'b0, funct3_q[1:0]};
                end
                if (lat_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid    = 1'b1;
                resp_rdata    = rdata_q;
                resp_rd       = resp_rd_q;
                resp_we       = resp_we_q;
                resp_misalign = misalign_q;
                resp_fault    = fault_q;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected responses,
// a negedge monitor pops them on each accepted response beat.
module tb_mem_access_unit;

    localparam int XLEN      = 64;
    localparam int MEM_BYTES = 4096;
    localparam int MEM_LAT   = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_is_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;
    logic            mem_write_en;
    logic            mem_read_en;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data_input;
    logic [1:0]      store_format;
    logic [2:0]      load_format;
    logic [XLEN-1:0] mem_data_output;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [4:0]      resp_rd;
    logic            resp_we;
    logic            resp_misalign;
    logic            resp_fault;
    logic            busy;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
        .mem_data_input(mem_data_input), .store_format(store_format), .load_format(load_format),
        .mem_data_output(mem_data_output),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_we(resp_we), .resp_misalign(resp_misalign),
        .resp_fault(resp_fault), .busy(busy)
    );

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   resp_seen     = 0;

    int          win_cnt      = 0;
    int          win_total    = 0;
    int          win_len_last = 0;
    logic        win_wr_last  = 1'b0;
    logic [1:0]  sfmt_cur     = '0;
    logic [2:0]  lfmt_cur     = '0;
    logic [63:0] wdata_cur    = '0;
    logic [1:0]  sfmt_last    = '0;
    logic [2:0]  lfmt_last    = '0;
    logic [63:0] wdata_last   = '0;

    logic [7:0] mem [MEM_BYTES];

    // Byte-addressed memory model; upper read bytes carry junk so masking is exercised.
    always_comb begin
        mem_data_output = '0;
        for (int i = 0; i < 8; i++) begin
            mem_data_output[8*i +: 8] = mem[12'(mem_addr[11:0] + 12'(i))];
        end
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (1 << store_format)) begin
                    mem[12'(mem_addr[11:0] + 12'(i))] <= mem_data_input[8*i +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic timeoutFail(input string name);
        checks_total++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic exp_t mk(input logic [63:0] rdata, input logic [4:0] rd,
                                input logic we, input logic mis, input logic flt);
        exp_t e;
        e.rdata = rdata; e.rd = rd; e.we = we; e.mis = mis; e.flt = flt;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            resp_seen++;
            if (sb_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL unexpected_resp: got a response beat rdata=0x%0h expected none", resp_rdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("resp_rdata",    resp_rdata,    e.rdata);
                checkOutput("resp_rd",       64'(resp_rd),  64'(e.rd));
                checkOutput("resp_we",       64'(resp_we),  64'(e.we));
                checkOutput("resp_misalign", 64'(resp_misalign), 64'(e.mis));
                checkOutput("resp_fault",    64'(resp_fault),    64'(e.flt));
            end
        end
    end

    // Tracks each enable window: length, direction, formats and store data.
    always @(negedge clk) begin
        if (mem_write_en || mem_read_en) begin
            if (mem_write_en && mem_read_en) checkOutput("enables_exclusive", 64'd1, 64'd0);
            win_cnt++;
            win_wr_last = mem_write_en;
            sfmt_cur    = store_format;
            lfmt_cur    = load_format;
            wdata_cur   = mem_data_input;
        end else if (win_cnt != 0) begin
            win_len_last = win_cnt;
            sfmt_last    = sfmt_cur;
            lfmt_last    = lfmt_cur;
            wdata_last   = wdata_cur;
            win_total++;
            win_cnt = 0;
        end
    end

    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [63:0] a,
                                 input logic [63:0] wd, input logic [4:0] rd, input exp_t e);
        bit accepted = 0;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        req_valid    = 1'b1;
        sb_q.push_back(e);
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                accepted = 1;
            end
        end
        #1 req_valid = 1'b0;
        if (!accepted) timeoutFail("request_accept");
    endtask

    task automatic waitDone();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && req_ready) done = 1;
        end
        if (!done) timeoutFail("transaction_done");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nwin;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i * 7 + 3);
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = '0;
        req_addr     = '0;
        req_wdata    = '0;
        req_rd       = '0;
        resp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 64'(req_ready),    64'd1);
        checkOutput("reset_busy",      64'(busy),         64'd0);
        checkOutput("reset_resp_valid",64'(resp_valid),   64'd0);
        checkOutput("reset_write_en",  64'(mem_write_en), 64'd0);
        checkOutput("reset_read_en",   64'(mem_read_en),  64'd0);
        checkOutput("reset_mem_addr",  mem_addr,          64'd0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 3'b011, 64'h10, 64'h8877665544332211, 5'd2, mk(64'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        waitDone();
        checkOutput("sd_window_len", 64'(win_len_last), 64'(MEM_LAT));
        checkOutput("sd_window_wr",  64'(win_wr_last),  64'd1);
        checkOutput("sd_store_fmt",  64'(sfmt_last),    64'd3);
        checkOutput("sd_wdata",      wdata_last,        64'h8877665544332211);

        applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, 5'd3, mk(64'h8877665544332211, 5'd3, 1'b1, 1'b0, 1'b0));
        waitDone();
        checkOutput("ld_window_wr", 64'(win_wr_last), 64'd0);
        checkOutput("ld_load_fmt",  64'(lfmt_last),   64'b101);

        applyStimulus(1'b1, 3'b000, 64'h20, 64'hFF, 5'd4, mk(64'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        waitDone();
        checkOutput("sb_store_fmt", 64'(sfmt_last), 64'd0);
        applyStimulus(1'b0, 3'b000, 64'h20, 64'd0, 5'd5, mk(64'hFFFFFFFFFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b0));
        waitDone();
        checkOutput("lb_load_fmt", 64'(lfmt_last), 64'd0);
        applyStimulus(1'b0, 3'b100, 64'h20, 64'd0, 5'd6, mk(64'h00000000000000FF, 5'd6, 1'b1, 1'b0, 1'b0));
        waitDone();
        checkOutput("lbu_load_fmt", 64'(lfmt_last), 64'd0);

        applyStimulus(1'b1, 3'b010, 64'h30, 64'h80000001, 5'd0, mk(64'd0, 5'd0, 1'b0, 1'b0, 1'b0));
        waitDone();
        applyStimulus(1'b0, 3'b010, 64'h30, 64'd0, 5'd7, mk(64'hFFFFFFFF80000001, 5'd7, 1'b1, 1'b0, 1'b0));
        waitDone();
        checkOutput("lw_load_fmt", 64'(lfmt_last), 64'b010);
        applyStimulus(1'b0, 3'b110, 64'h30, 64'd0, 5'd8, mk(64'h0000000080000001, 5'd8, 1'b1, 1'b0, 1'b0));
        waitDone();
        applyStimulus(1'b0, 3'b001, 64'h30, 64'd0, 5'd9, mk(64'h0000000000000001, 5'd9, 1'b1, 1'b0, 1'b0));
        waitDone();
        applyStimulus(1'b0, 3'b000, 64'h30, 64'd0, 5'd0, mk(64'h0000000000000001, 5'd0, 1'b0, 1'b0, 1'b0));
        waitDone();

        nwin = win_total;
        applyStimulus(1'b0, 3'b010, 64'h32, 64'd0, 5'd10, mk(64'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        waitDone();
        checkOutput("misalign_no_read", 64'(win_total), 64'(nwin));
        applyStimulus(1'b1, 3'b011, 64'hFFC, 64'h1234, 5'd0, mk(64'd0, 5'd0, 1'b0, 1'b1, 1'b1));
        waitDone();
        applyStimulus(1'b1, 3'b010, 64'hFFE0_0000, 64'h1234, 5'd0, mk(64'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        waitDone();
        applyStimulus(1'b0, 3'b111, 64'h40, 64'd0, 5'd1, mk(64'd0, 5'd0, 1'b0, 1'b1, 1'b0));
        waitDone();
        checkOutput("fault_no_write", 64'(win_total), 64'(nwin));

        resp_ready = 1'b0;
        applyStimulus(1'b0, 3'b010, 64'h30, 64'd0, 5'd11, mk(64'hFFFFFFFF80000001, 5'd11, 1'b1, 1'b0, 1'b0));
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (resp_valid) seen = 1;
            end
            if (!seen) timeoutFail("hold_resp_valid_rise");
        end
        @(posedge clk);
        #1;
        req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = 64'h20; req_rd = 5'd12; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("hold_resp_rdata", resp_rdata,      64'hFFFFFFFF80000001);
            checkOutput("hold_req_ready",  64'(req_ready),  64'd0);
        end
        sb_q.push_back(mk(64'hFFFFFFFFFFFFFFFF, 5'd12, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 checkOutput("release_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 checkOutput("release_next_accepted", 64'(busy), 64'd1);
        req_valid = 1'b0;
        waitDone();

        nwin = resp_seen;
        req_is_store = 1'b1; req_funct3 = 3'b011; req_addr = 64'h40; req_wdata = 64'h55AA; req_rd = 5'd0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checkOutput("abort_write_en_active", 64'(mem_write_en), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_write_en",   64'(mem_write_en), 64'd0);
        checkOutput("abort_read_en",    64'(mem_read_en),  64'd0);
        checkOutput("abort_resp_valid", 64'(resp_valid),   64'd0);
        checkOutput("abort_req_ready",  64'(req_ready),    64'd1);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_no_response", 64'(resp_seen), 64'(nwin));
        checkOutput("scoreboard_empty",  64'(sb_q.size()), 64'd0);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
